pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the pipelined RV32 core, generalising the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries a control bundle and a data bundle between stages using a valid/ready handshake. It supports stall back-pressure, flush (bubble insertion) and a saturating stall counter. An optional two-entry skid buffer registers the upstream ready.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg_sat_counter.sv | 21 ++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and per-stage bundle widths for the RV32 pipeline stage registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_e;

   // Control/data bundle widths for each inter-stage register of the core
   localparam int IF_ID_CTRL_W  = 2;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 12;
   localparam int ID_EX_DATA_W  = 112;
   localparam int EX_MEM_CTRL_W = 8;
   localparam int EX_MEM_DATA_W = 104;
   localparam int MEM_WB_CTRL_W = 4;
   localparam int MEM_WB_DATA_W = 69;

   function automatic logic [1:0] occToCount(input occ_state_e s);
      return logic'(s == TWO) ? 2'd2 : ((s == ONE) ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle around one pipeline stage register.
// slave is the stage register itself, master is the surrounding pipeline.
interface pipe_stage_reg_if #(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data
   );

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data
   );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; state changes on the falling edge.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);
   logic [W-1:0] count_q;

   always_ff @(negedge clk) begin
      if (clear) begin
         count_q <= '0;
      end else if (en && (count_q != {W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready, flush bubbles and a stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   pipe_stage_reg_if.slave  bus,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);
   occ_state_e        state_q, state_d;
   logic [CTRL_W-1:0] mainCtrl_q;
   logic [DATA_W-1:0] mainData_q;
   logic              outValid;
   logic              inReady;
   logic              accBeat;
   logic              relBeat;

   assign outValid = (state_q != EMPTY);
   assign accBeat  = bus.in_valid && inReady;
   assign relBeat  = outValid && bus.out_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
   logic [CTRL_W-1:0] skidCtrl_q;
   logic [DATA_W-1:0] skidData_q;
   logic              inReady_q;

   assign inReady = inReady_q && !flush;

   // in_ready comes straight from a flop so upstream never sees a path from out_ready
   always_ff @(negedge clk) begin
      if (rst) begin
         inReady_q <= 1'b1;
      end else begin
         inReady_q <= (state_d != TWO);
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         skidCtrl_q <= '0;
         skidData_q <= '0;
      end else if (flush) begin
         skidCtrl_q <= '0;
      end else if (accBeat && (state_q == ONE) && !relBeat) begin
         skidCtrl_q <= bus.in_ctrl;
         skidData_q <= bus.in_data;
      end
   end
`else
   assign inReady = !flush && (!outValid || bus.out_ready);
`endif

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accBeat) state_d = ONE;
`ifdef PIPE_STAGE_SKID_EN
            ONE: begin
               if (accBeat && !relBeat) begin
                  state_d = TWO;
               end else if (relBeat && !accBeat) begin
                  state_d = EMPTY;
               end
            end
`else
            ONE: if (relBeat && !accBeat) state_d = EMPTY;
`endif
            TWO:     if (relBeat) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Main entry always holds the oldest beat; data is kept across bubbles, ctrl is not
   always_ff @(negedge clk) begin
      if (rst) begin
         mainCtrl_q <= '0;
         mainData_q <= '0;
      end else if (flush) begin
         mainCtrl_q <= '0;
      end else if (accBeat && ((state_q == EMPTY) || relBeat)) begin
         mainCtrl_q <= bus.in_ctrl;
         mainData_q <= bus.in_data;
`ifdef PIPE_STAGE_SKID_EN
      end else if ((state_q == TWO) && relBeat) begin
         mainCtrl_q <= skidCtrl_q;
         mainData_q <= skidData_q;
`endif
      end
   end

   always_comb begin
      bus.in_ready  = inReady;
      bus.out_valid = outValid;
      bus.out_ctrl  = outValid ? mainCtrl_q : '0;
      bus.out_data  = mainData_q;
`ifdef PIPE_STAGE_SKID_EN
      occupancy     = occToCount(state_q);
`else
      occupancy     = {1'b0, outValid};
`endif
   end

   sat_counter #(
      .W(CNT_W)
   ) uStallCnt (
      .clk  (clk),
      .clear(rst),
      .en   (outValid && !bus.out_ready),
      .count(stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a FIFO reference model predicts handshakes,
// occupancy and the stall counter; a monitor checks every released beat in order.
module tb_pipe_stage_reg;
   localparam int CTRL_W = 12;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int SAT    = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

   pipe_stage_reg #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (bus),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   beat_t             modelQ[$];
   beat_t             expQ[$];
   int                modelCnt = 0;
   logic [DATA_W-1:0] lastData = '0;
   int                errors = 0;
   int                checks = 0;
   bit                lastAcc = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit modelReady(input bit ordy, input bit fl);
      int n = modelQ.size();
      if (fl) return 1'b0;
      if (CAP == 2) return (n < 2);
      return (n == 0) || ordy;
   endfunction

   task automatic checkOutput(input bit ordy, input bit fl);
      int n = modelQ.size();
      check("in_ready", 64'(bus.in_ready), 64'(modelReady(ordy, fl)));
      check("out_valid", 64'(bus.out_valid), 64'(n > 0));
      check("occupancy", 64'(occupancy), 64'(n));
      check("stall_cnt", 64'(stall_cnt), 64'(modelCnt));
      if (n == 0) begin
         check("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
         check("held_data", 64'(bus.out_data), 64'(lastData));
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                input bit ordy, input bit fl, input bit rs);
      int    n;
      bit    acc;
      bit    rel;
      beat_t b;
      @(posedge clk);
      bus.in_valid  = v;
      bus.in_ctrl   = c;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush         = fl;
      rst           = rs;
      #1;
      checkOutput(ordy, fl);
      n   = modelQ.size();
      acc = v && modelReady(ordy, fl) && !rs;
      rel = (n > 0) && ordy && !fl && !rs;
      b   = '{ctrl: c, data: d};
      lastAcc = acc;
      if (rs) begin
         modelQ.delete();
         expQ.delete();
         modelCnt = 0;
         lastData = '0;
      end else begin
         if ((n > 0) && !ordy && (modelCnt < SAT)) modelCnt++;
         if (fl) begin
            modelQ.delete();
            expQ.delete();
         end else begin
            if (rel) void'(modelQ.pop_front());
            if (acc) begin
               modelQ.push_back(b);
               expQ.push_back(b);
            end
         end
         if (modelQ.size() > 0) lastData = modelQ[0].data;
      end
   endtask

   // Monitor: every released beat must be the oldest one the scoreboard holds
   always @(posedge clk) begin
      beat_t e;
      #2;
      if (!rst && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got ctrl 0x%0h data 0x%0h expected no beat", bus.out_ctrl, bus.out_data);
         end else begin
            e = expQ.pop_front();
            check("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
            check("out_data", 64'(bus.out_data), 64'(e.data));
         end
      end
   end

   initial begin
      logic [CTRL_W-1:0] pc;
      logic [DATA_W-1:0] pd;
      bit                pv;
      bus.in_valid  = 1'b0;
      bus.in_ctrl   = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] streaming");
      applyStimulus(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1, CTRL_W'(i + 1), DATA_W'(32'h100 + i), 1, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 1, 0, 0);

      $display("[TB] back-pressure");
      applyStimulus(1, 12'hA0A, 32'hAAAA_0001, 0, 0, 0);
      applyStimulus(1, 12'hB0B, 32'hBBBB_0002, 0, 0, 0);
      applyStimulus(1, 12'hC0C, 32'hCCCC_0003, 0, 0, 0);
      applyStimulus(1, 12'hC0C, 32'hCCCC_0003, 0, 0, 0);
      applyStimulus(1, 12'hC0C, 32'hCCCC_0003, 1, 0, 0);
      applyStimulus(1, 12'hC0C, 32'hCCCC_0003, 1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 1, 0, 0);

      $display("[TB] saturation");
      applyStimulus(1, 12'h0D1, 32'hD000_0001, 0, 0, 0);
      repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] flush");
      applyStimulus(1, 12'h0E2, 32'hE000_0002, 0, 0, 0);
      applyStimulus(1, 12'h0F3, 32'hF000_0003, 0, 1, 0);
      repeat (2) applyStimulus(0, 0, 0, 1, 0, 0);

      $display("[TB] reset mid-stall");
      applyStimulus(0, 0, 0, 1, 0, 1);
      applyStimulus(1, 12'h011, 32'h1111_0000, 0, 0, 0);
      applyStimulus(1, 12'h022, 32'h2222_0000, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 12'h033, 32'h3333_0000, 0, 0, 1);
      applyStimulus(1, 12'h044, 32'h4444_0000, 1, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 1, 0, 0);

      $display("[TB] random traffic");
      pv = 1'b0;
      pc = '0;
      pd = '0;
      for (int i = 0; i < 400; i++) begin
         bit ordy;
         bit fl;
         bit rs;
         if (!pv || lastAcc) begin
            pv = ($urandom_range(0, 3) != 0);
            pc = CTRL_W'($urandom);
            pd = DATA_W'($urandom);
         end
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 39) == 0);
         rs   = ($urandom_range(0, 99) == 0);
         applyStimulus(pv, pc, pd, ordy, fl, rs);
         if (fl || rs) pv = 1'b0;
      end
      repeat (4) applyStimulus(0, 0, 0, 1, 0, 0);
      check("scoreboard_drained", 64'(expQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
